wdrr_scheduler: RTL

WDRR_SCHEDULER -- requirements
Module: wdrr_scheduler

---
 rtl/wdrr_scheduler.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/wdrr_scheduler.sv
// Weighted deficit round-robin scheduler.
// Visits queues in pointer order, tops up each nonempty queue's deficit by
// its quantum once per visit, and grants head packets while they fit in the
// deficit. Grants are held on a valid/ready handshake.
module wdrr_scheduler #(
  parameter int QUEUES_NUM     = 64,
  parameter int QUEUES_NUM_BIT = 6,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int LEN_WIDTH      = 16,
  parameter int DEFICIT_WIDTH  = 18
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 sched_en,
  input  logic [QUEUES_NUM-1:0]                q_nonempty,
  input  logic [QUEUES_NUM*LEN_WIDTH-1:0]      q_head_len,
  input  logic [QUEUES_NUM*AXI_DATA_WIDTH-1:0] quantum_in,
  output logic                                 grant_valid,
  output logic [QUEUES_NUM_BIT-1:0]            grant_qid,
  output logic [LEN_WIDTH-1:0]                 grant_len,
  input  logic                                 grant_ready,
  output logic [QUEUES_NUM*AXI_DATA_WIDTH-1:0] deficit_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    GRANT = 2'd2
  } state_t;

  state_t                      state_q, state_d;
  logic [QUEUES_NUM_BIT-1:0]   ptr_q, ptr_d;
  logic                        fresh_q, fresh_d;
  logic                        grant_valid_d;
  logic [QUEUES_NUM_BIT-1:0]   grant_qid_d;
  logic [LEN_WIDTH-1:0]        grant_len_d;

  logic [DEFICIT_WIDTH-1:0]    deficit_q [QUEUES_NUM];
  logic                        def_we;
  logic [QUEUES_NUM_BIT-1:0]   def_idx;
  logic [DEFICIT_WIDTH-1:0]    def_wdata;

  logic [LEN_WIDTH-1:0]        head_len_a [QUEUES_NUM];
  logic [LEN_WIDTH-1:0]        quantum_a  [QUEUES_NUM];

  logic                        cur_nonempty;
  logic [DEFICIT_WIDTH-1:0]    cur_len;
  logic [DEFICIT_WIDTH-1:0]    cur_def;
  logic [DEFICIT_WIDTH:0]      cur_sum;
  logic [DEFICIT_WIDTH-1:0]    cur_sat;
  logic [QUEUES_NUM_BIT-1:0]   ptr_inc;
  logic                        unused_quantum_bits;

  // Only the low LEN_WIDTH bits of each quantum slice matter; fold the rest
  // into a sink so the whole port is consumed.
  assign unused_quantum_bits = ^quantum_in;

  // Unpack the flat per-queue buses into indexable arrays.
  always_comb begin
    for (int i = 0; i < QUEUES_NUM; i++) begin
      head_len_a[i] = q_head_len[i*LEN_WIDTH +: LEN_WIDTH];
      quantum_a[i]  = quantum_in[i*AXI_DATA_WIDTH +: LEN_WIDTH];
    end
  end

  // Values of the queue under the pointer, plus the saturating top-up.
  assign cur_nonempty = q_nonempty[ptr_q];
  assign cur_len      = DEFICIT_WIDTH'(head_len_a[ptr_q]);
  assign cur_def      = deficit_q[ptr_q];
  assign cur_sum      = {1'b0, cur_def} + (DEFICIT_WIDTH+1)'(quantum_a[ptr_q]);
  assign cur_sat      = cur_sum[DEFICIT_WIDTH] ? '1 : cur_sum[DEFICIT_WIDTH-1:0];
  assign ptr_inc      = (ptr_q == QUEUES_NUM_BIT'(QUEUES_NUM - 1)) ? '0 : ptr_q + 1'b1;

  // Next-state, pointer, grant and single-port deficit write decisions.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no branch can
    // leave one unassigned and infer a latch.
    state_d       = state_q;
    ptr_d         = ptr_q;
    fresh_d       = fresh_q;
    grant_valid_d = grant_valid;
    grant_qid_d   = grant_qid;
    grant_len_d   = grant_len;
    def_we        = 1'b0;
    def_idx       = ptr_q;
    def_wdata     = cur_sat;

    case (state_q)
      IDLE: begin
        if (sched_en && (|q_nonempty)) state_d = CHECK;
      end
      CHECK: begin
        if (!sched_en) begin
          state_d = IDLE;
        end else if (!cur_nonempty) begin
          // An empty queue forfeits any accumulated credit.
          def_we    = 1'b1;
          def_wdata = '0;
          ptr_d     = ptr_inc;
          fresh_d   = 1'b1;
          if (!(|q_nonempty)) state_d = IDLE;
        end else if (fresh_q) begin
          def_we  = 1'b1;
          fresh_d = 1'b0;
        end else if (cur_len <= cur_def) begin
          grant_valid_d = 1'b1;
          grant_qid_d   = ptr_q;
          grant_len_d   = head_len_a[ptr_q];
          state_d       = GRANT;
        end else begin
          ptr_d   = ptr_inc;
          fresh_d = 1'b1;
        end
      end
      GRANT: begin
        if (grant_ready) begin
          // The compare that issued this grant guarantees no underflow.
          def_we        = 1'b1;
          def_idx       = grant_qid;
          def_wdata     = deficit_q[grant_qid] - DEFICIT_WIDTH'(grant_len);
          grant_valid_d = 1'b0;
          state_d       = CHECK;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and grant registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      fresh_q     <= 1'b1;
      grant_valid <= 1'b0;
      grant_qid   <= '0;
      grant_len   <= '0;
    end else begin
      // NOTE: non-blocking assignments make every register here update from
      // the same pre-edge values, independent of statement order.
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      fresh_q     <= fresh_d;
      grant_valid <= grant_valid_d;
      grant_qid   <= grant_qid_d;
      grant_len   <= grant_len_d;
    end
  end

  // Deficit counters, one write per cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the counters are flops, not RAM, and are reset because they are
      // read back and steer scheduling immediately after reset.
      for (int i = 0; i < QUEUES_NUM; i++) deficit_q[i] <= '0;
    end else if (def_we) begin
      deficit_q[def_idx] <= def_wdata;
    end
  end

  // Zero-extended register readback of every counter.
  always_comb begin
    deficit_out = '0;
    for (int i = 0; i < QUEUES_NUM; i++) begin
      deficit_out[i*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] = AXI_DATA_WIDTH'(deficit_q[i]);
    end
  end

endmodule
